// File: rtl/normalize_pkg.sv
// normalize_pkg: shared widths, state encoding and stage-count helper for the normalize datapath
package normalize_pkg;
  localparam int NORM_WIDTH = 48;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} normState_t;
  function automatic int normSw(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/norm_stage.sv
// norm_stage: one binary-search step, shifts left by 2**k when the top 2**k bits are all zero
module norm_stage
  import normalize_pkg::*;
#(
  parameter int N = NORM_WIDTH,
  parameter int SW = normSw(N)
) (
  input  logic [N-1:0]  wIn,
  input  logic [SW-1:0] k,
  output logic [N-1:0]  wOut,
  output logic          take
);
  logic [N-1:0] shifted [SW];
  logic [SW-1:0] takeVec;
  for (genvar s = 0; s < SW; s++) begin : g_stage
    localparam int P = 1 << s;
    if (P >= N) begin : g_skip
      assign takeVec[s] = 1'b0;
      assign shifted[s] = wIn;
    end else begin : g_live
      assign takeVec[s] = wIn[N-1 -: P] == '0;
      assign shifted[s] = wIn << P;
    end
  end
  always_comb begin
    take = takeVec[k];
    wOut = take ? shifted[k] : wIn;
  end
endmodule

// File: rtl/left_normalizer.sv
// left_normalizer: multi-cycle leading-zero normalizer with valid/ready on both sides
module left_normalizer
  import normalize_pkg::*;
#(
  parameter int N = NORM_WIDTH
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [N-1:0]         In,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [N-1:0]         Out,
  output logic [normSw(N)-1:0] ShiftLeftAmount,
  output logic                 Zero
);
  localparam int SW = normSw(N);
  normState_t state;
  logic [SW-1:0] k;
  logic [SW-1:0] amt;
  logic [N-1:0] w;
  logic [N-1:0] stageW;
  logic take;
  logic zero;
  norm_stage #(.N(N), .SW(SW)) uStage (
    .wIn (w),
    .k   (k),
    .wOut(stageW),
    .take(take)
  );
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      k     <= '0;
      amt   <= '0;
      w     <= '0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (InValid) begin
          w     <= In;
          amt   <= '0;
          k     <= SW'(SW - 1);
          zero  <= In == '0;
          state <= (In == '0) ? DONE : SHIFT;
        end
        SHIFT: begin
          w     <= stageW;
          amt   <= take ? amt + (SW'(1) << k) : amt;
          k     <= (k == '0) ? k : k - 1'b1;
          state <= (k == '0) ? DONE : SHIFT;
        end
        DONE: if (OutReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    InReady         = state == IDLE;
    OutValid        = state == DONE;
    Out             = w;
    ShiftLeftAmount = amt;
    Zero            = zero;
  end
endmodule

// File: tb/tb_left_normalizer.sv
// tb_left_normalizer: directed checks of normalization results, latency, backpressure and reset
module tb_left_normalizer;
  localparam int N = 48;
  logic Clock = 1'b0;
  logic Reset, InValid, OutReady;
  logic [N-1:0] In;
  logic InReady, OutValid, Zero;
  logic [N-1:0] Out;
  logic [5:0] ShiftLeftAmount;
  int checks = 0;
  int errors = 0;
  int lat;

  left_normalizer #(.N(N)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady), .In(In),
    .OutValid(OutValid), .OutReady(OutReady), .Out(Out),
    .ShiftLeftAmount(ShiftLeftAmount), .Zero(Zero)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call right after the accept edge; lat is the cycle index (accept cycle = 0) where OutValid rises.
  task automatic waitValid(output int l);
    l = 1;
    while (!OutValid && l < 30) begin
      step();
      l++;
    end
  endtask

  task automatic runOp(input string tag, input logic [N-1:0] v, input logic [N-1:0] eOut,
                       input logic [5:0] eAmt, input logic eZero, input int eLat);
    chk({tag, ".inReady"}, 64'(InReady), 64'd1);
    In = v;
    InValid = 1'b1;
    step();
    InValid = 1'b0;
    In = '1;
    waitValid(lat);
    chk({tag, ".latency"}, 64'(lat), 64'(eLat));
    chk({tag, ".out"}, 64'(Out), 64'(eOut));
    chk({tag, ".amt"}, 64'(ShiftLeftAmount), 64'(eAmt));
    chk({tag, ".zero"}, 64'(Zero), 64'(eZero));
    step();
    chk({tag, ".validDrop"}, 64'(OutValid), 64'd0);
  endtask

  initial begin
    Reset = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b1;
    In = '0;
    step();
    step();
    Reset = 1'b0;
    chk("reset.inReady", 64'(InReady), 64'd1);
    chk("reset.outValid", 64'(OutValid), 64'd0);
    chk("reset.out", 64'(Out), 64'd0);
    chk("reset.amt", 64'(ShiftLeftAmount), 64'd0);
    chk("reset.zero", 64'(Zero), 64'd0);

    runOp("one", 48'h0000_0000_0001, 48'h8000_0000_0000, 6'd47, 1'b0, 7);
    runOp("msb", 48'h8000_0000_0000, 48'h8000_0000_0000, 6'd0, 1'b0, 7);
    runOp("f0", 48'h0000_00F0_0000, 48'hF000_0000_0000, 6'd24, 1'b0, 7);
    runOp("zero", 48'h0, 48'h0, 6'd0, 1'b1, 1);
    runOp("mixed", 48'h0000_1234_5678, 48'h91A2_B3C0_0000, 6'd19, 1'b0, 7);
    runOp("lz1", 48'h7FFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFE, 6'd1, 1'b0, 7);

    // Backpressure with a second operand waiting on InValid throughout.
    OutReady = 1'b0;
    In = 48'h0000_0000_0003;
    InValid = 1'b1;
    step();
    In = 48'h0000_0000_0100;
    waitValid(lat);
    chk("bp.latency", 64'(lat), 64'd7);
    for (int i = 0; i < 10; i++) begin
      chk("bp.outValid", 64'(OutValid), 64'd1);
      chk("bp.inReady", 64'(InReady), 64'd0);
      chk("bp.out", 64'(Out), 64'hC000_0000_0000);
      chk("bp.amt", 64'(ShiftLeftAmount), 64'd46);
      step();
    end
    OutReady = 1'b1;
    chk("bp.holdValid", 64'(OutValid), 64'd1);
    step();
    chk("bp.afterHsValid", 64'(OutValid), 64'd0);
    chk("bp.afterHsReady", 64'(InReady), 64'd1);
    step();
    InValid = 1'b0;
    chk("bp.secondAccepted", 64'(InReady), 64'd0);
    waitValid(lat);
    chk("bp.second.latency", 64'(lat), 64'd7);
    chk("bp.second.out", 64'(Out), 64'h8000_0000_0000);
    chk("bp.second.amt", 64'(ShiftLeftAmount), 64'd39);
    step();

    // Reset while SHIFT is at stage k=2 (three edges after accept).
    In = 48'h0000_0000_0001;
    InValid = 1'b1;
    step();
    InValid = 1'b0;
    step();
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midReset.inReady", 64'(InReady), 64'd1);
    chk("midReset.outValid", 64'(OutValid), 64'd0);
    chk("midReset.out", 64'(Out), 64'd0);
    chk("midReset.amt", 64'(ShiftLeftAmount), 64'd0);
    runOp("postReset", 48'h0000_0000_0100, 48'h8000_0000_0000, 6'd39, 1'b0, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/left_normalizer.md
Name: left_normalizer

Overview:
- Multi-cycle left-normalizer for the fixed-point adder datapath, the complement of the right-shift alignment stage.
- Takes an N-bit magnitude and shifts it left until bit N-1 is 1. Reports the shift applied so the exponent/scale can be corrected downstream.
- Runs one binary-search stage per clock, largest stage first.
- Uses valid/ready handshakes on both input and output.

Parameters:
- N, 48, datapath width in bits; N >= 2.
- SW, $clog2(N) (localparam), width of ShiftLeftAmount and number of search stages.

Ports:
- Clock  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  In holds a valid operand.
- InReady  output  1  block can accept an operand this cycle.
- In  input  N  unsigned magnitude to normalize.
- OutValid  output  1  Out/ShiftLeftAmount/Zero are valid.
- OutReady  input  1  consumer accepts the result this cycle.
- Out  output  N  normalized value; Out[N-1]=1 unless Zero.
- ShiftLeftAmount  output  SW  total left shift applied; equals the leading-zero count of In.
- Zero  output  1  In was all zeros.

Behaviour:
- Reset values (any state, including mid-operation): state IDLE, InReady=1, OutValid=0, Out=0, ShiftLeftAmount=0, Zero=0. Any in-flight operand is discarded.
- States:
  - IDLE: InReady=1.
  - SHIFT: InReady=0, stage index k counts SW-1 down to 0.
  - DONE: InReady=0, OutValid=1.
- Accept: fires when InValid && InReady at an edge.
  - In==0: go to DONE with Out=0, ShiftLeftAmount=0, Zero=1.
  - Otherwise: load working register W=In, Amt=0, k=SW-1, go to SHIFT.
- SHIFT, each edge:
  - Skip condition: if 2**k >= N, the stage is skipped (no shift) without consuming extra bookkeeping. It still occupies its cycle, so latency stays fixed.
  - Shift condition: otherwise, if W[N-1 -: 2**k]==0, then W <= W << 2**k and Amt <= Amt + 2**k.
  - Stage exit: if k==0, go to DONE; else k <= k-1.
- Latency:
  - Non-zero operand: OutValid is first high SW+1 cycles after the accept cycle (SW SHIFT edges plus the DONE entry; accept edge counts as cycle 0). For N=48 that is 7 cycles.
  - Zero operand: OutValid high in cycle 1.
- DONE: Out=W, ShiftLeftAmount=Amt. Outputs are held stable while OutValid && !OutReady, for unlimited backpressure.
  - When OutReady=1, go to IDLE next edge; OutValid drops next cycle.
  - No same-cycle accept of a new operand in DONE. Throughput is one operand per SW+2 cycles.
- In is sampled only at accept; changes to In while busy are ignored.
- Arithmetic: Amt never exceeds N-1 for a non-zero input, so no overflow. Bits shifted out are always zero by construction.
- Reset asserted in the same cycle as an accept or a DONE handshake: reset wins, and no output is produced.

Decomposition:
- Shared package normalize_pkg holds:
  - the state enum {IDLE, SHIFT, DONE};
  - a function returning SW for a given N;
  - default width constants shared with the right-shift alignment stage, so both use identical N.
- One natural sub-module: norm_stage. It is a combinational single-stage conditional left shifter: inputs W, k; outputs shifted W and a take flag. It is instantiated once and reused across cycles.
- Control FSM and registers stay in left_normalizer.

Test Plan:
- N=48, In=48'h0000_0000_0001, OutReady=1 -> Out=48'h8000_0000_0000, ShiftLeftAmount=47, Zero=0, OutValid first high 7 cycles after accept.
- In=48'h8000_0000_0000 -> Out unchanged, ShiftLeftAmount=0, Zero=0, latency still 7.
- In=48'h0000_00F0_0000 -> Out=48'hF000_0000_0000, ShiftLeftAmount=24.
- In=0 -> Zero=1, Out=0, ShiftLeftAmount=0, OutValid in cycle 1.
- Backpressure: OutReady=0 for 10 cycles after OutValid; then 1 -> outputs stable throughout. InReady=0 until the cycle after the handshake. A second operand held on InValid is accepted only then.
- Reset asserted in SHIFT at k=2 -> next cycle InReady=1, OutValid=0, Out=0. The following operand In=48'h0000_0000_0100 gives ShiftLeftAmount=39 with normal latency.
